// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings and FSM state constants shared with ALU_Controller.
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL;
  endfunction
endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: request/result bundle between an issuing stage and alu_exec.
interface alu_exec_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [4:0]       shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  modport master (output start, alu_control, operand_a, operand_b, shamt,
                  input busy, done, result, zero, overflow);
  modport slave (input start, alu_control, operand_a, operand_b, shamt,
                 output busy, done, result, zero, overflow);
endinterface

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: serial zero-fill shifter, one bit per cycle after load.
module alu_shift_seq #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             left,
  input  logic [4:0]       amount,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] shifted,
  output logic             finished
);
  logic [WIDTH-1:0] value;
  logic [4:0]       count;
  logic             left_q;
  // shifted is the value after this cycle's step; finished flags the final step
  assign shifted  = left_q ? value << 1 : value >> 1;
  assign finished = count == 5'd1;
  always_ff @(posedge clk)
    if (reset) begin
      value  <= '0;
      count  <= '0;
      left_q <= 1'b0;
    end else if (load) begin
      value  <= din;
      count  <= amount;
      left_q <= left;
    end else if (count != 5'd0) begin
      value <= shifted;
      count <= count - 5'd1;
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: single-issue ALU; logic/arith ops in one cycle, shifts via serial shifter.
module alu_exec import alu_pkg::*; #(parameter int WIDTH = 32) (
  input logic       clk,
  input logic       reset,
  alu_exec_if.slave bus
);
  logic [0:0]       state;
  logic [WIDTH-1:0] a, b, sum, diff, res_c, sh_val, result;
  logic             ovf_c, accept, sh_go, sh_last, done, zero, overflow;
  assign a      = bus.operand_a;
  assign b      = bus.operand_b;
  assign sum    = a + b;
  assign diff   = a - b;
  assign accept = bus.start && state == ST_IDLE;
  assign sh_go  = accept && is_shift(bus.alu_control) && bus.shamt != 5'd0;
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (bus.alu_control)
      ALU_AND:  res_c = a & b;
      ALU_OR:   res_c = a | b;
      ALU_NOR:  res_c = ~(a | b);
      ALU_ADD: begin
        res_c = sum;
        ovf_c = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      ALU_SUB: begin
        res_c = diff;
        ovf_c = a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
      end
      ALU_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res_c = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLL, ALU_SRL: res_c = b;
      default: ;
    endcase
  end
  alu_shift_seq #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_go),
    .left     (bus.alu_control == ALU_SLL),
    .amount   (bus.shamt),
    .din      (b),
    .shifted  (sh_val),
    .finished (sh_last)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_SHIFT) begin
        if (sh_last) begin
          state    <= ST_IDLE;
          done     <= 1'b1;
          result   <= sh_val;
          zero     <= sh_val == '0;
          overflow <= 1'b0;
        end
      end else if (sh_go) begin
        state <= ST_SHIFT;
      end else if (accept) begin
        done     <= 1'b1;
        result   <= res_c;
        zero     <= res_c == '0;
        overflow <= ovf_c;
      end
    end
  assign bus.busy     = state == ST_SHIFT;
  assign bus.done     = done;
  assign bus.result   = result;
  assign bus.zero     = zero;
  assign bus.overflow = overflow;
endmodule
